// File: rtl/manchester_encoder.sv
// -----------------------------------------------------------------------------
// manchester_encoder
//
// Transmit side of the smart-LED chain link. Bits forwarded by the protocol
// logic are buffered in a small FIFO. Each bit is then regenerated on the line
// as a Manchester symbol whose half-bit length comes from the pulse width
// measured on the receive side.
//
// Line coding : bit 1 = high then low, bit 0 = low then high, idle = low.
//
// Handshake   : the writer presents in_data with a single-cycle in_valid strobe.
//               A bit is accepted on any clk edge where in_valid=1 and
//               in_ready=1. in_ready is high whenever the FIFO has a free entry.
//               A strobe that arrives while the FIFO is full is dropped and sets
//               the sticky overflow flag, even if a pop frees an entry on that
//               same edge.
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous reset, active high
//   in_data      in   bit to transmit, sampled with in_valid
//   in_valid     in   single-cycle strobe, one per bit
//   in_ready     out  FIFO has a free entry
//   half_period  in   half-bit length in clk cycles (clamped to MIN_HALF)
//   out          out  registered Manchester line output
//   busy         out  a bit is on the line or the FIFO holds bits
//   overflow     out  sticky: a strobe was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module manchester_encoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int PW_WIDTH   = 6,
  parameter int MIN_HALF   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [PW_WIDTH-1:0] half_period,
  output logic                out,
  output logic                busy,
  output logic                overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0]       DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [PW_WIDTH-1:0] MIN_H   = PW_WIDTH'(MIN_HALF);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FIRST,
    S_SECOND
  } state_t;

  // FIFO storage
  logic [FIFO_DEPTH-1:0] r_mem;
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;

  // Symbol generator
  state_t                r_state;
  logic [PW_WIDTH-1:0]   r_cnt;
  logic [PW_WIDTH-1:0]   r_h;
  logic                  r_bit;
  logic                  r_out;
  logic                  r_overflow;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic [PW_WIDTH-1:0]   w_h;

  state_t                w_state_nxt;
  logic [PW_WIDTH-1:0]   w_cnt_nxt;
  logic [PW_WIDTH-1:0]   w_h_nxt;
  logic                  w_bit_nxt;
  logic                  w_out_nxt;

  assign w_full   = (r_count == DEPTH_C);
  assign w_empty  = (r_count == '0);
  assign w_push   = in_valid && !w_full;
  assign w_h      = (half_period < MIN_H) ? MIN_H : half_period;

  assign in_ready = !w_full;
  assign out      = r_out;
  assign overflow = r_overflow;
  assign busy     = (r_state != S_IDLE) || !w_empty;

  // Next-state logic. w_pop doubles as the "load a new symbol" flag: a pop
  // always starts the first half of the popped bit on the same edge, which
  // is what lets back-to-back bits run with no idle cycle between them.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_h_nxt     = r_h;
    w_bit_nxt   = r_bit;
    w_out_nxt   = r_out;
    w_pop       = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_out_nxt = 1'b0;
        w_pop     = !w_empty;
      end
      S_FIRST: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_SECOND;
          w_cnt_nxt   = r_h - 1'b1;
          w_out_nxt   = ~r_bit;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_SECOND: begin
        if (r_cnt == '0) begin
          if (w_empty) begin
            w_state_nxt = S_IDLE;
            w_out_nxt   = 1'b0;
          end else begin
            w_pop = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_out_nxt   = 1'b0;
      end
    endcase

    if (w_pop) begin
      w_state_nxt = S_FIRST;
      w_bit_nxt   = r_mem[r_rd_ptr];
      w_h_nxt     = w_h;
      w_cnt_nxt   = w_h - 1'b1;
      w_out_nxt   = r_mem[r_rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_h        <= MIN_H;
      r_bit      <= 1'b0;
      r_out      <= 1'b0;
      r_overflow <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_mem      <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_h     <= w_h_nxt;
      r_bit   <= w_bit_nxt;
      r_out   <= w_out_nxt;

      if (in_valid && w_full) begin
        r_overflow <= 1'b1;
      end

      if (w_push) begin
        r_mem[r_wr_ptr] <= in_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_manchester_encoder.sv
// -----------------------------------------------------------------------------
// tb_manchester_encoder
//
// Directed-vector bench for manchester_encoder. Inputs change and outputs are
// sampled on the falling clk edge. Expected line patterns are written out by
// hand, MSB = first sampled cycle.
// -----------------------------------------------------------------------------
module tb_manchester_encoder;

  localparam int PW_WIDTH = 6;

  logic                clk;
  logic                rst;
  logic                in_data;
  logic                in_valid;
  logic                in_ready;
  logic [PW_WIDTH-1:0] half_period;
  logic                out;
  logic                busy;
  logic                overflow;

  int n_checks;
  int n_fail;

  manchester_encoder #(
    .FIFO_DEPTH (4),
    .PW_WIDTH   (PW_WIDTH),
    .MIN_HALF   (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .half_period (half_period),
    .out         (out),
    .busy        (busy),
    .overflow    (overflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Sample out on the next n falling edges against pat[n-1] .. pat[0].
  task automatic check_stream(input string tag, input logic [63:0] pat, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check(tag, {31'd0, out}, {31'd0, pat[n-1-i]});
    end
  endtask

  // Strobe one bit into the FIFO; returns on the falling edge after the write.
  task automatic push_bit(input logic b, input logic [PW_WIDTH-1:0] hp);
    in_data     = b;
    half_period = hp;
    in_valid    = 1'b1;
    @(negedge clk);
    in_valid    = 1'b0;
  endtask

  logic [7:0] a5;
  logic [5:0] burst;
  logic       exp_bit;

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_data     = 1'b0;
    half_period = 6'd4;
    @(negedge clk);
    do_reset();

    // reset state
    check("rst_out",      {31'd0, out},      32'd0);
    check("rst_busy",     {31'd0, busy},     32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // single bit 1, H=4
    push_bit(1'b1, 6'd4);
    check("t1_pre_out",  {31'd0, out},  32'd0);
    check("t1_pre_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t1_out",  {31'd0, out},  (i < 4) ? 32'd1 : 32'd0);
      check("t1_busy", {31'd0, busy}, 32'd1);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t1_idle_out",  {31'd0, out},  32'd0);
      check("t1_idle_busy", {31'd0, busy}, 32'd0);
    end

    // 0xA5 MSB-first, strobes every 8 cycles, H=4: continuous stream
    do_reset();
    a5 = 8'hA5;
    fork
      begin
        for (int i = 7; i >= 0; i--) begin
          push_bit(a5[i], 6'd4);
          repeat (7) @(negedge clk);
        end
      end
      begin
        @(negedge clk);
        check_stream("t2_a5", 64'hF00F_F00F_0FF0_0FF0 ^ 64'h0, 0);
        check_stream("t2_b7", 64'h00F0, 8);
        check_stream("t2_b6", 64'h000F, 8);
        check_stream("t2_b5", 64'h00F0, 8);
        check_stream("t2_b4", 64'h000F, 8);
        check_stream("t2_b3", 64'h000F, 8);
        check_stream("t2_b2", 64'h00F0, 8);
        check_stream("t2_b1", 64'h000F, 8);
        check_stream("t2_b0", 64'h00F0, 8);
      end
    join
    check("t2_overflow", {31'd0, overflow}, 32'd0);
    check_stream("t2_tail", 64'h0, 4);

    // half_period 0 then 1: both clamp to H=2
    do_reset();
    in_data     = 1'b0;
    half_period = 6'd0;
    in_valid    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    in_valid    = 1'b0;
    half_period = 6'd1;
    check("t3_b0_first", {31'd0, out}, 32'd0);
    check_stream("t3_clamp", 64'b0110011, 7);
    check_stream("t3_tail",  64'h0, 4);

    // half_period change during first half: 4 -> 8 affects only the next bit
    do_reset();
    in_data     = 1'b1;
    half_period = 6'd4;
    in_valid    = 1'b1;
    @(negedge clk);
    in_data     = 1'b0;
    @(negedge clk);
    in_valid    = 1'b0;
    half_period = 6'd8;
    check("t5_first", {31'd0, out}, 32'd1);
    for (int j = 0; j < 28; j++) begin
      @(negedge clk);
      if (j < 3)       exp_bit = 1'b1;
      else if (j < 15) exp_bit = 1'b0;
      else if (j < 23) exp_bit = 1'b1;
      else             exp_bit = 1'b0;
      check("t5_hchange", {31'd0, out}, {31'd0, exp_bit});
    end

    // 6 strobes on consecutive cycles, H=10: 1 popped, 4 queued, 6th dropped
    do_reset();
    burst       = 6'b101101;   // burst[0] sent first
    half_period = 6'd10;
    for (int i = 0; i < 6; i++) begin
      in_data  = burst[i];
      in_valid = 1'b1;
      @(negedge clk);
      check("t4_in_ready", {31'd0, in_ready}, (i < 4) ? 32'd1 : 32'd0);
      check("t4_overflow", {31'd0, overflow}, (i == 5) ? 32'd1 : 32'd0);
      if (i >= 1) check("t4_out_early", {31'd0, out}, {31'd0, burst[0]});
    end
    in_valid = 1'b0;
    for (int k = 6; k <= 110; k++) begin
      @(negedge clk);
      if (k > 100) exp_bit = 1'b0;
      else if (((k - 1) % 20) < 10) exp_bit = burst[(k - 1) / 20];
      else exp_bit = ~burst[(k - 1) / 20];
      check("t4_stream", {31'd0, out}, {31'd0, exp_bit});
    end
    check("t4_overflow_sticky", {31'd0, overflow}, 32'd1);
    check("t4_busy_done",       {31'd0, busy},     32'd0);

    // reset mid-SECOND with 2 bits queued (no reset beforehand: overflow is 1)
    in_data     = 1'b0;
    half_period = 6'd4;
    in_valid    = 1'b1;
    repeat (3) @(negedge clk);
    in_valid    = 1'b0;
    repeat (4) @(negedge clk);
    check("t6_pre_out",  {31'd0, out},  32'd1);
    check("t6_pre_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_out",      {31'd0, out},      32'd0);
    check("t6_busy",     {31'd0, busy},     32'd0);
    check("t6_in_ready", {31'd0, in_ready}, 32'd1);
    check("t6_overflow", {31'd0, overflow}, 32'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("t6_quiet_out",  {31'd0, out},  32'd0);
      check("t6_quiet_busy", {31'd0, busy}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/manchester_encoder.md
Name: manchester_encoder

Overview:
- Transmit side of the smart-LED chain link: re-encodes the bits forwarded by the protocol logic as a Manchester line signal for the next LED in the chain.
- Buffers incoming bit strobes in a small FIFO so decoder-side jitter does not corrupt output timing.
- Regenerates each bit with a half-bit duration taken from the pulse width measured on the receive side.

Parameters:
- FIFO_DEPTH, 4: bit FIFO entries; power of two, at least 2.
- PW_WIDTH, 6: width of the half_period input.
- MIN_HALF, 2: lower clamp on the half-bit length, in clk cycles.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active high
- in_data  input  1  bit to transmit; sampled when in_valid=1
- in_valid  input  1  single-cycle strobe, one per bit (driven from decoder out_clk, possibly swapped data)
- in_ready  output  1  1 when FIFO count < FIFO_DEPTH
- half_period  input  PW_WIDTH  half-bit length in clk cycles (decoder out_pulsewidth)
- out  output  1  Manchester line output, registered
- busy  output  1  1 while a bit is on the line or the FIFO is non-empty
- overflow  output  1  sticky; set when in_valid arrives while the FIFO is full

Behaviour:
- Reset (rst=1 at a clk edge) sets out=0, busy=0, overflow=0, FIFO empty, FSM=IDLE, and half counter=0. This applies at any point, including mid-bit; out is low after that edge.
- Encoding:
  - Bit 1: first half high, second half low.
  - Bit 0: first half low, second half high.
  - Idle line level is 0.
  - The end of a frame is signalled by the line staying low after the last bit.
- FIFO:
  - A write occurs on an edge with in_valid=1 and count<FIFO_DEPTH.
  - If in_valid=1 and count==FIFO_DEPTH, the bit is dropped and overflow is set. This applies even if a pop happens on the same edge.
  - A simultaneous push and pop with count<FIFO_DEPTH leaves the count unchanged.
  - Ordering is strict FIFO.
- Half length: H = max(half_period, MIN_HALF), latched when a bit is popped. Changes to half_period mid-bit have no effect on the current bit.
- FSM states: IDLE, FIRST, SECOND.
  - IDLE: out=0. On an edge where the FIFO is non-empty: pop, latch bit b and H, go to FIRST, load counter=H-1, out<=b on that same edge.
  - FIRST: count down each cycle. At counter==0: go to SECOND, counter=H-1, out<=~b.
  - SECOND: count down. At counter==0:
    - FIFO non-empty: pop the next bit directly into FIRST, with no idle cycle.
    - FIFO empty: go to IDLE with out<=0.
- Timing:
  - Each half lasts exactly H clk cycles.
  - A bit lasts 2H cycles.
  - With the FIFO empty and FSM IDLE, a bit written at edge t is popped at edge t+1. out shows the first-half level from edge t+1 through edge t+1+H.
- Back-to-back bits produce a continuous Manchester stream. A 1 followed by a 0 yields a single 2H-long low period spanning the boundary.
- busy = (FSM != IDLE) || (count != 0).
- in_ready is combinational from the registered count.
- Counter width is PW_WIDTH; H ≤ 2^PW_WIDTH−1, so there is no wrap.

Test Plan:
- Reset, then in_valid with in_data=1, half_period=4 → out=1 for 4 cycles, out=0 for 4 cycles, then stays 0; busy high for exactly 8 cycles after the pop edge.
- Push 0xA5 MSB-first as 8 strobes spaced 8 cycles apart, H=4 → out pattern 10 01 10 01 01 10 01 10, each symbol 4 cycles, no gaps; overflow stays 0.
- half_period=0, then 1, each with in_data=0 → both bits use H=2: out low 2 cycles, high 2 cycles.
- 6 strobes on consecutive cycles with FIFO_DEPTH=4, H=10 → first bit popped, 4 queued, 6th dropped; in_ready=0 while the count is 4; overflow=1 and remains set until rst.
- Change half_period from 4 to 8 during the first half of a bit → current bit keeps H=4; the next popped bit uses H=8.
- Assert rst for one cycle mid-SECOND with 2 bits queued → next cycle out=0, busy=0, in_ready=1, overflow=0; no queued bits are transmitted afterwards.
